// File: rtl/alu_control.sv
// Registered MIPS ALU-control decoder for the execute stage.
// Maps ALUOp plus the R-type funct field to an ALU operation code.
module alu_control #(
  parameter logic [3:0] RESET_CON = 4'b0010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] ALUOp,
  input  logic [5:0] funct,
  output logic [3:0] ALUCon,
  output logic       illegal,
  output logic       is_shift
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  logic [3:0] con_d;
  logic       ill_d;
  logic       sh_d;
  logic [3:0] rt_con;
  logic       rt_ill;
  logic       rt_sh;

  // R-type table; ALUOp[0] plays no part here
  always_comb begin
    rt_con = OP_ADD;
    rt_ill = 1'b0;
    rt_sh  = 1'b0;
    case (funct)
      6'b100000: rt_con = OP_ADD;
      6'b100001: rt_con = OP_ADD;
      6'b100010: rt_con = OP_SUB;
      6'b100011: rt_con = OP_SUB;
      6'b100100: rt_con = OP_AND;
      6'b100101: rt_con = OP_OR;
      6'b100110: rt_con = OP_XOR;
      6'b100111: rt_con = OP_NOR;
      6'b101010: rt_con = OP_SLT;
      6'b101011: rt_con = OP_SLTU;
      6'b000000: begin rt_con = OP_SLL; rt_sh = 1'b1; end
      6'b000010: begin rt_con = OP_SRL; rt_sh = 1'b1; end
      6'b000011: begin rt_con = OP_SRA; rt_sh = 1'b1; end
      6'b000100: begin rt_con = OP_SLL; rt_sh = 1'b1; end
      6'b000110: begin rt_con = OP_SRL; rt_sh = 1'b1; end
      6'b000111: begin rt_con = OP_SRA; rt_sh = 1'b1; end
      6'b001000: rt_con = OP_ADD;
      default:   rt_ill = 1'b1;
    endcase
  end

  always_comb begin
    con_d = OP_ADD;
    ill_d = 1'b0;
    sh_d  = 1'b0;
    unique case (1'b1)
      (ALUOp == 2'b00): con_d = OP_ADD;
      (ALUOp == 2'b01): con_d = OP_SUB;
      ALUOp[1]: begin
        con_d = rt_con;
        ill_d = rt_ill;
        sh_d  = rt_sh;
      end
      default: con_d = OP_ADD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALUCon   <= RESET_CON;
      illegal  <= 1'b0;
      is_shift <= 1'b0;
    end else if (en) begin
      ALUCon   <= con_d;
      illegal  <= ill_d;
      is_shift <= sh_d;
    end
  end

endmodule

// File: tb/tb_alu_control.sv
// Directed bench for alu_control with a queue of expected outputs.
// Each step drives inputs, queues the expectation, and checks after the edge.
module tb_alu_control;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] ALUOp;
  logic [5:0] funct;
  logic [3:0] ALUCon;
  logic       illegal;
  logic       is_shift;

  int total = 0;
  int bad   = 0;

  logic [3:0] q_con[$];
  logic       q_ill[$];
  logic       q_sh[$];
  string      q_tag[$];

  alu_control #(.RESET_CON(4'b0010)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .ALUOp    (ALUOp),
    .funct    (funct),
    .ALUCon   (ALUCon),
    .illegal  (illegal),
    .is_shift (is_shift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1, "timeout");
  end

  task automatic expect_out(input logic [3:0] c, input logic il,
                            input logic s, input string t);
    q_con.push_back(c);
    q_ill.push_back(il);
    q_sh.push_back(s);
    q_tag.push_back(t);
  endtask

  task automatic check();
    logic [3:0] c;
    logic       il;
    logic       s;
    string      t;
    total++;
    if (q_con.size() == 0) begin
      bad++;
      $error("FAIL scoreboard: queue empty, got %b/%b/%b",
             ALUCon, illegal, is_shift);
      return;
    end
    c  = q_con.pop_front();
    il = q_ill.pop_front();
    s  = q_sh.pop_front();
    t  = q_tag.pop_front();
    assert ({ALUCon, illegal, is_shift} === {c, il, s})
    else begin
      bad++;
      $error("FAIL %s: got con=%b ill=%b sh=%b want con=%b ill=%b sh=%b",
             t, ALUCon, illegal, is_shift, c, il, s);
    end
  endtask

  task automatic step(input logic [1:0] op, input logic [5:0] f,
                      input logic e, input logic [3:0] c,
                      input logic il, input logic s, input string t);
    ALUOp = op;
    funct = f;
    en    = e;
    expect_out(c, il, s, t);
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    ALUOp = 2'b00;
    funct = 6'b000000;
    #2;
    expect_out(4'b0010, 1'b0, 1'b0, "reset_init");
    check();
    @(negedge clk);
    reset = 1'b0;

    step(2'b00, 6'b100000, 1'b1, 4'b0010, 1'b0, 1'b0, "op00_add");
    step(2'b01, 6'b100000, 1'b1, 4'b0110, 1'b0, 1'b0, "op01_sub");
    step(2'b00, 6'b100010, 1'b1, 4'b0010, 1'b0, 1'b0, "op00_f22");
    step(2'b01, 6'b100010, 1'b1, 4'b0110, 1'b0, 1'b0, "op01_f22");
    step(2'b01, 6'b111111, 1'b1, 4'b0110, 1'b0, 1'b0, "op01_fff");
    step(2'b10, 6'b100000, 1'b1, 4'b0010, 1'b0, 1'b0, "op10_add");
    step(2'b11, 6'b100000, 1'b1, 4'b0010, 1'b0, 1'b0, "op11_add");
    step(2'b10, 6'b100010, 1'b1, 4'b0110, 1'b0, 1'b0, "op10_sub");
    step(2'b11, 6'b100010, 1'b1, 4'b0110, 1'b0, 1'b0, "op11_sub");
    step(2'b11, 6'b100101, 1'b1, 4'b0001, 1'b0, 1'b0, "op11_or");
    step(2'b11, 6'b100100, 1'b1, 4'b0000, 1'b0, 1'b0, "op11_and");
    step(2'b10, 6'b100001, 1'b1, 4'b0010, 1'b0, 1'b0, "addu");
    step(2'b10, 6'b100011, 1'b1, 4'b0110, 1'b0, 1'b0, "subu");
    step(2'b10, 6'b100110, 1'b1, 4'b0011, 1'b0, 1'b0, "xor");
    step(2'b10, 6'b100111, 1'b1, 4'b1100, 1'b0, 1'b0, "nor");
    step(2'b10, 6'b101010, 1'b1, 4'b0111, 1'b0, 1'b0, "slt");
    step(2'b10, 6'b101011, 1'b1, 4'b1000, 1'b0, 1'b0, "sltu");
    step(2'b10, 6'b000000, 1'b1, 4'b1001, 1'b0, 1'b1, "sll");
    step(2'b10, 6'b000010, 1'b1, 4'b1010, 1'b0, 1'b1, "srl");
    step(2'b10, 6'b000011, 1'b1, 4'b1011, 1'b0, 1'b1, "sra");
    step(2'b11, 6'b000100, 1'b1, 4'b1001, 1'b0, 1'b1, "sllv");
    step(2'b10, 6'b000110, 1'b1, 4'b1010, 1'b0, 1'b1, "srlv");
    step(2'b10, 6'b000111, 1'b1, 4'b1011, 1'b0, 1'b1, "srav");
    step(2'b10, 6'b001000, 1'b1, 4'b0010, 1'b0, 1'b0, "jr");
    step(2'b10, 6'b111111, 1'b1, 4'b0010, 1'b1, 1'b0, "illegal_3f");
    step(2'b11, 6'b000001, 1'b1, 4'b0010, 1'b1, 1'b0, "illegal_01");
    step(2'b00, 6'b111111, 1'b1, 4'b0010, 1'b0, 1'b0, "illegal_clr");

    step(2'b10, 6'b100110, 1'b1, 4'b0011, 1'b0, 1'b0, "pre_hold");
    step(2'b10, 6'b000011, 1'b0, 4'b0011, 1'b0, 1'b0, "hold_sra");
    step(2'b10, 6'b111111, 1'b0, 4'b0011, 1'b0, 1'b0, "hold_ill");

    step(2'b10, 6'b100000, 1'b1, 4'b0010, 1'b0, 1'b0, "en_add");
    step(2'b10, 6'b100101, 1'b0, 4'b0010, 1'b0, 1'b0, "en0_or");
    en = 1'b1;
    #1;
    expect_out(4'b0010, 1'b0, 1'b0, "en1_pre_edge");
    check();
    @(posedge clk);
    #1;
    expect_out(4'b0001, 1'b0, 1'b0, "en1_or");
    check();

    step(2'b10, 6'b000011, 1'b1, 4'b1011, 1'b0, 1'b1, "pre_reset");
    #1;
    reset = 1'b1;
    #1;
    expect_out(4'b0010, 1'b0, 1'b0, "reset_mid");
    check();
    @(posedge clk);
    #1;
    expect_out(4'b0010, 1'b0, 1'b0, "reset_held");
    check();
    @(negedge clk);
    reset = 1'b0;
    step(2'b10, 6'b101010, 1'b1, 4'b0111, 1'b0, 1'b0, "post_reset");
    step(2'b10, 6'b111110, 1'b1, 4'b0010, 1'b1, 1'b0, "post_illegal");

    if (q_con.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: %0d entries left", q_con.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
